fifo_uart_tx: RTL and testbench

- Drains the team's 16-entry byte FIFO from its read side and serialises each byte as an 8N1 asynchronous serial frame on `txd`, with an optional even-parity bit.
- Sits between the FIFO read port (`Ren`/`Fempty`/data out) and the board UART pin.
- It is the sole reader of its FIFO.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_cnt.sv | 32 +++
 rtl/fifo_uart_tx.sv | 147 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state type, frame constants and small
// helper functions used by both the transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_t;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_IDLE      = 1'b1;

  // Bit-timer width; never narrower than one bit.
  function automatic int bit_timer_w(input int clks);
    return (clks < 2) ? 1 : $clog2(clks);
  endfunction

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: tick marks the last ck cycle of every bit period,
// clr holds the count at zero while no bit is being timed.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic ck,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = bit_timer_w(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_r;

  assign tick = (cnt_r == LAST);

  // Count up, wrapping only at the end of a bit period.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (clr || tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + W'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one byte at a time from the byte FIFO
// and sends it as an 8N1 frame (optionally with even parity) on txd.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       en,
  input  logic       Fempty,
  input  logic [7:0] Fdout,
  output logic       Ren,
  output logic       txd,
  output logic       busy,
  output logic       tx_done
);

  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  tx_state_t                 state_r, state_s;
  logic [UART_DATA_BITS-1:0] shift_r, shift_s;
  logic [IDX_W-1:0]          idx_r, idx_s;
  logic                      par_r, par_s;
  logic                      txd_r, txd_s;
  logic                      ren_r, ren_s;
  logic                      done_r, done_s;
  logic                      clr_s, tick_s;

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .ck   (ck),
    .rst  (rst),
    .clr  (clr_s),
    .tick (tick_s)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    idx_s   = idx_r;
    par_s   = par_r;
    txd_s   = txd_r;
    ren_s   = 1'b0;
    done_s  = 1'b0;
    clr_s   = 1'b1;
    case (state_r)
      IDLE: begin
        txd_s = UART_IDLE;
        if (en && !Fempty) begin
          ren_s   = 1'b1;
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        state_s = LOAD;
      end
      LOAD: begin
        shift_s = Fdout;
        par_s   = even_parity(Fdout);
        txd_s   = 1'b0;
        state_s = START;
      end
      START: begin
        clr_s = 1'b0;
        if (tick_s) begin
          txd_s   = shift_r[0];
          idx_s   = '0;
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        clr_s = 1'b0;
        if (!tick_s) begin
          state_s = DATA;
        end else if (idx_r != LAST_IDX) begin
          // Next data bit is the one about to land in shift[0].
          shift_s = {1'b0, shift_r[UART_DATA_BITS-1:1]};
          idx_s   = idx_r + IDX_W'(1);
          txd_s   = shift_r[1];
          state_s = DATA;
        end else if (PARITY_EN) begin
          txd_s   = par_r;
          state_s = PARITY;
        end else begin
          txd_s   = UART_IDLE;
          state_s = STOP;
        end
      end
      PARITY: begin
        clr_s = 1'b0;
        if (tick_s) begin
          txd_s   = UART_IDLE;
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
      STOP: begin
        clr_s = 1'b0;
        if (tick_s) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        txd_s   = UART_IDLE;
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      shift_r <= '0;
      idx_r   <= '0;
      par_r   <= 1'b0;
      txd_r   <= UART_IDLE;
      ren_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      idx_r   <= idx_s;
      par_r   <= par_s;
      txd_r   <= txd_s;
      ren_r   <= ren_s;
      done_r  <= done_s;
    end
  end

  assign Ren     = ren_r;
  assign txd     = txd_r;
  assign tx_done = done_r;
  assign busy    = (state_r != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (no parity / even parity) driven in
// lockstep from FIFO models, compared every cycle against a frame-timeline model.
module tb_fifo_uart_tx;

  localparam int N  = 4;
  localparam int NI = 2;

  logic          ck = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [NI-1:0] fempty;
  logic [7:0]    fdout [NI];
  logic [NI-1:0] ren, txd, busy, done;

  always #5 ck = ~ck;

  fifo_uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b0)) dut0 (
    .ck(ck), .rst(rst), .en(en), .Fempty(fempty[0]), .Fdout(fdout[0]),
    .Ren(ren[0]), .txd(txd[0]), .busy(busy[0]), .tx_done(done[0]));

  fifo_uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1)) dut1 (
    .ck(ck), .rst(rst), .en(en), .Fempty(fempty[1]), .Fdout(fdout[1]),
    .Ren(ren[1]), .txd(txd[1]), .busy(busy[1]), .tx_done(done[1]));

  // FIFO contents as seen by each DUT, and the byte order the model expects.
  logic [7:0] q    [NI][$];
  logic [7:0] expq [NI][$];

  // Model: a frame is a list of line levels, each held N cycles; age counts
  // edges since the IDLE decision (age 1 = Ren cycle, age 2 = Fdout cycle).
  bit   m_active [NI];
  int   m_age    [NI];
  int   nbits    [NI];
  logic fbits    [NI][11];
  logic e_txd [NI], e_ren [NI], e_busy [NI], e_done [NI];

  int cyc = 0;
  int last_ren [NI];
  int meas_len [NI];
  bit burst = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc%0d: got %0d expected %0d", name, i, cyc, act, expv);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: cycle budget expired at cyc%0d", name, cyc);
  endtask

  task automatic build_frame(input int i, input logic [7:0] b);
    int ones = 0;
    fbits[i][0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      fbits[i][k+1] = b[k];
      ones += int'(b[k]);
    end
    if (i == 1) begin
      fbits[i][9]  = (ones % 2 == 1);
      fbits[i][10] = 1'b1;
      nbits[i] = 11;
    end else begin
      fbits[i][9] = 1'b1;
      nbits[i] = 10;
    end
  endtask

  // Advance the model across the coming rising edge.
  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      if (!rst) begin
        m_active[i] = 1'b0;
        m_age[i] = 0;
      end else if (m_active[i]) begin
        m_age[i]++;
      end else if (en && expq[i].size() > 0) begin
        build_frame(i, expq[i].pop_front());
        m_active[i] = 1'b1;
        m_age[i] = 1;
      end
      e_txd[i] = 1'b1; e_ren[i] = 1'b0; e_busy[i] = 1'b0; e_done[i] = 1'b0;
      if (m_active[i]) begin
        e_busy[i] = 1'b1;
        if (m_age[i] == 1) begin
          e_ren[i] = 1'b1;
        end else if (m_age[i] >= 3 && m_age[i] - 3 < nbits[i] * N) begin
          e_txd[i] = fbits[i][(m_age[i] - 3) / N];
        end else if (m_age[i] == 3 + nbits[i] * N) begin
          e_busy[i] = 1'b0;
          e_done[i] = 1'b1;
          m_active[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic check();
    for (int i = 0; i < NI; i++) begin
      chk("txd", i, 32'(txd[i]), 32'(e_txd[i]));
      chk("ren", i, 32'(ren[i]), 32'(e_ren[i]));
      chk("busy", i, 32'(busy[i]), 32'(e_busy[i]));
      chk("tx_done", i, 32'(done[i]), 32'(e_done[i]));
      if (ren[i] === 1'b1) begin
        chk("ren_while_empty", i, 32'(fempty[i]), 32'd0);
        if (burst && last_ren[i] >= 0)
          chk("byte_rate", i, cyc - last_ren[i], (i == 0) ? 43 : 47);
        last_ren[i] = cyc;
      end
      if (done[i] === 1'b1) meas_len[i] = cyc - (last_ren[i] + 2);
    end
    cyc++;
  endtask

  task automatic fifo_update();
    for (int i = 0; i < NI; i++) begin
      if (ren[i] === 1'b1 && q[i].size() > 0) fdout[i] = q[i].pop_front();
      fempty[i] = (q[i].size() == 0);
    end
  endtask

  task automatic step();
    model_edge();
    @(negedge ck);
    check();
    fifo_update();
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < NI; i++) begin
      q[i].push_back(b);
      expq[i].push_back(b);
      fempty[i] = 1'b0;
    end
  endtask

  function automatic bit all_idle();
    return !m_active[0] && !m_active[1] && expq[0].size() == 0 && expq[1].size() == 0;
  endfunction

  task automatic run_until_idle(input int limit);
    int k = 0;
    while (!all_idle() && k < limit) begin
      step();
      k++;
    end
    if (!all_idle()) timeout("run_until_idle");
    step();
  endtask

  task automatic wait_age(input int target);
    int k = 0;
    while (!(m_active[0] && m_age[0] == target) && k < 400) begin
      step();
      k++;
    end
    if (!(m_active[0] && m_age[0] == target)) timeout("wait_age");
  endtask

  logic [9:0] lit_a5;

  initial begin
    for (int i = 0; i < NI; i++) begin
      fdout[i] = 8'h00;
      last_ren[i] = -1;
      meas_len[i] = 0;
      m_active[i] = 1'b0;
      m_age[i] = 0;
    end
    fempty = '1;
    #1 rst = 1'b0;

    // Reset held with a byte waiting and en high.
    push_byte(8'hA5);
    en = 1'b1;
    for (int k = 0; k < 3; k++) step();
    rst = 1'b1;
    step();
    chk("first_ren_after_reset", 0, 32'(ren[0]), 32'd1);

    // Single byte 0xA5 on both instances.
    run_until_idle(200);
    chk("frame_len_8n1", 0, meas_len[0], 40);
    chk("frame_len_8e1", 1, meas_len[1], 44);
    chk("fempty_after", 0, 32'(fempty[0]), 32'd1);
    lit_a5 = 10'b1101001010;
    build_frame(0, 8'hA5);
    for (int k = 0; k < 10; k++) chk("model_bits_a5", k, 32'(fbits[0][k]), 32'(lit_a5[k]));
    build_frame(1, 8'hA5);
    chk("model_parity_a5", 1, 32'(fbits[1][9]), 32'd0);
    build_frame(1, 8'h07);
    chk("model_parity_07", 1, 32'(fbits[1][9]), 32'd1);

    // Parity pair 0xA5, 0x07.
    push_byte(8'hA5);
    push_byte(8'h07);
    run_until_idle(300);
    chk("frame_len_parity", 1, meas_len[1], 44);

    // Full FIFO burst.
    for (int b = 0; b < 16; b++) push_byte(8'(b));
    burst = 1'b1;
    last_ren[0] = -1;
    last_ren[1] = -1;
    run_until_idle(1200);
    burst = 1'b0;

    // Enable dropped during data bit 3 of the first of two frames.
    push_byte(8'h3C);
    push_byte(8'hC3);
    wait_age(3 + 4 * N + 1);
    en = 1'b0;
    for (int k = 0; k < 80; k++) step();
    chk("held_frame_pending", 0, q[0].size(), 1);
    en = 1'b1;
    step();
    chk("ren_after_enable", 0, 32'(ren[0]), 32'd1);
    run_until_idle(200);

    // Asynchronous reset during data bit 5; the next byte must still go out.
    push_byte(8'h5A);
    push_byte(8'h81);
    wait_age(3 + 6 * N + 1);
    @(posedge ck);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("async_txd", i, 32'(txd[i]), 32'd1);
      chk("async_busy", i, 32'(busy[i]), 32'd0);
      chk("async_ren", i, 32'(ren[i]), 32'd0);
    end
    step();
    step();
    rst = 1'b1;
    run_until_idle(200);
    chk("after_reset_len", 0, meas_len[0], 40);

    // Random traffic with random enable toggling.
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 3) == 0 && q[0].size() < 16 && q[1].size() < 16)
        push_byte(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 29) == 0) en = ~en;
      step();
    end
    en = 1'b1;
    run_until_idle(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
